// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FSM encodings, default tap count and accumulator sizing for the FIR MAC
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } fir_state_t;

  localparam int TAPS_DEF = 6;

  // Headroom for TAPS full-width products summed without overflow.
  function automatic int acc_width(input int bits_x, input int bits_a, input int taps);
    return bits_x + bits_a + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - TAPS-deep sample shift register with indexed parallel read
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int W     = 16,
  parameter int IDX_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic signed [W-1:0] din,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic signed [W-1:0] rd_data
);

  logic signed [W-1:0] taps_q [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
    end else if (shift_en) begin
      taps_q[0] <= din;
      for (int i = 1; i < TAPS; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  // Explicit select keeps out-of-range indices reading zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (int'(rd_idx) == i) rd_data = taps_q[i];
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - time-multiplexed FIR MAC driving an external coefficient ROM; FIR_SAT_EN selects saturating output
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int bits_I = 3,
  parameter int bits_A = 16,
  parameter int bits_X = 16,
  parameter int bits_Y = 16,
  parameter int FRAC   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [bits_X-1:0] x_in,
  output logic [bits_I-1:0]        coef_addr,
  input  logic signed [bits_A-1:0] coef_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [bits_Y-1:0] y_out
);

  localparam int ACC_W  = acc_width(bits_X, bits_A, TAPS);
  localparam int PROD_W = bits_X + bits_A;
  localparam int K_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

  fir_state_t               state;
  logic [K_W-1:0]           k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [bits_X-1:0] x_k;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [bits_Y-1:0] y_red;
  logic                     shift_en;

  assign shift_en = (state == S_IDLE) && in_valid;

  fir_delay_line #(
    .TAPS  (TAPS),
    .W     (bits_X),
    .IDX_W (K_W)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (x_in),
    .rd_idx   (k),
    .rd_data  (x_k)
  );

  assign prod     = x_k * coef_in;
  assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign shifted  = acc_next >>> FRAC;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-bits_Y+1){1'b0}}, {(bits_Y-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-bits_Y+1){1'b1}}, {(bits_Y-1){1'b0}}};

  always_comb begin
    y_red = shifted[bits_Y-1:0];
    if (shifted > Y_MAX)      y_red = Y_MAX[bits_Y-1:0];
    else if (shifted < Y_MIN) y_red = Y_MIN[bits_Y-1:0];
  end
`else
  assign y_red = shifted[bits_Y-1:0];
`endif

  // The final tap's product is folded in combinationally so y_out lands on the same edge as DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      acc       <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      coef_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc       <= '0;
            k         <= '0;
            in_ready  <= 1'b0;
            coef_addr <= bits_I'(TAPS);
            state     <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (k == K_LAST) begin
            y_out     <= y_red;
            out_valid <= 1'b1;
            coef_addr <= '0;
            k         <= '0;
            state     <= S_DONE;
          end else begin
            k         <= k + 1'b1;
            coef_addr <= bits_I'(TAPS - 1 - int'(k));
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          coef_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - directed and random checks of fir_mac_seq against an array-based FIR model
module tb_fir_mac_seq;

  localparam int TAPS = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] x_in = '0;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_in;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] y_out;

  int nchk = 0;
  int nerr = 0;

  int coef [TAPS] = '{0, 1, 7, 7, 1, 0};
  int hist [TAPS];
  int exp_y;

  always #5 clk = ~clk;

  // ROM: address 1..TAPS holds a(TAPS-1)..a0.
  function automatic logic signed [15:0] rom(input logic [2:0] a);
    int idx;
    idx = TAPS - int'(a);
    if (a == 3'd0 || idx < 0 || idx >= TAPS) return '0;
    return 16'(coef[idx]);
  endfunction

  assign coef_in = rom(coef_addr);

  fir_mac_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .coef_addr (coef_addr),
    .coef_in   (coef_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out)
  );

  task automatic chk(input string tag, input longint obs, input longint expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
  endtask

  // y[n] = sum ak*x[n-k], then reduced to 16 bits.
  task automatic model_push(input int x);
    longint s;
    logic signed [63:0] s64;
    logic signed [15:0] w;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(coef[i]) * longint'(hist[i]);
`ifdef FIR_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    s64 = s;
    w = s64[15:0];
    exp_y = int'(w);
  endtask

  task automatic start_sample(input int x);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    x_in = 16'(x);
    model_push(x);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts cycles from the acceptance cycle; poke drives stray in_valid/out_ready mid-MAC.
  task automatic wait_out(input bit poke);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (poke && lat == 2) begin
        in_valid = 1'b1;
        x_in = 16'sd12345;
        out_ready = 1'b1;
      end
      if (poke && lat == 4) begin
        in_valid = 1'b0;
        out_ready = 1'b0;
      end
      if (!out_valid && lat <= TAPS) chk("coef_addr", coef_addr, TAPS - (lat - 1));
    end while (!out_valid && lat < 30);
    chk("latency", lat, TAPS + 1);
    chk("y_out", y_out, exp_y);
    chk("in_ready_done", in_ready, 0);
  endtask

  task automatic finish_out(input int hold);
    logic signed [15:0] y0;
    y0 = y_out;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_y", y_out, y0);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  task automatic run_sample(input int x, input int hold, input bit poke);
    start_sample(x);
    wait_out(poke);
    finish_out(hold);
  endtask

  initial begin
    int seen;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_coef_addr", coef_addr, 0);
    chk("rst_y_out", y_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse response.
    run_sample(1, 0, 0);
    for (int i = 0; i < 5; i++) run_sample(0, 0, 0);

    // Step response.
    for (int i = 0; i < 6; i++) run_sample(100, 0, 0);

    // Backpressure.
    run_sample(-37, 10, 0);

    // Reset in the middle of MAC.
    start_sample(55);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_coef_addr", coef_addr, 0);
    chk("midrst_y_out", y_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("no_stale_valid", seen, 0);
    chk("idle_in_ready", in_ready, 1);
    run_sample(1, 0, 0);
    for (int i = 0; i < 5; i++) run_sample(0, 0, 0);

    // Overflow.
    for (int i = 0; i < 6; i++) run_sample(32767, 0, 0);

    // Negative impulse.
    run_sample(-2, 0, 0);
    for (int i = 0; i < 5; i++) run_sample(0, 0, 0);

    // in_valid together with out_ready in DONE: only the output handshake completes.
    start_sample(9);
    wait_out(0);
    in_valid = 1'b1;
    x_in = 16'sd300;
    out_ready = 1'b1;
    @(negedge clk);
    chk("done_in_out_valid", out_valid, 0);
    chk("done_in_not_taken", in_ready, 1);
    out_ready = 1'b0;
    model_push(300);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("idle_accept", in_ready, 0);
    wait_out(0);
    finish_out(0);

    // Stray in_valid/out_ready during MAC are ignored.
    run_sample(-500, 0, 1);
    run_sample(7, 1, 0);

    // Random samples with random backpressure.
    for (int i = 0; i < 20; i++) begin
      run_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)), 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
